par_gen_stream: RTL and testbench

- Streaming, parametrised successor to the combinational parity generator.
- Generator mode: appends a parity bit (even or odd, selectable per word) to each DATA_W-bit input word.
- Checker mode: verifies received DATA_W+1-bit words, flags errors and keeps a saturating error count.
- Sits between a valid/ready producer and consumer, with a 2-entry buffer for full throughput under backpressure.

---
 rtl/par_pkg.sv | 17 +
 rtl/par_skid_fifo.sv | 70 +++++++
 rtl/par_gen_stream.sv | 88 ++++++++
 tb/tb_par_gen_stream.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/par_pkg.sv
// Shared constants and the parity helper for the streaming parity generator/checker.
package par_pkg;

    localparam int DATA_W_DEF = 7;
    localparam int CNT_W_DEF  = 8;

    // Widest vector the parity helper accepts; callers zero-extend into it.
    localparam int PAR_MAX_W  = 64;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic parity(input logic [PAR_MAX_W-1:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/par_skid_fifo.sv
// Two-entry valid/ready FIFO with registered outputs; the head register drives out_data directly.
module par_skid_fifo #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   occ_q, occ_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push, pop;

    assign in_ready  = (occ_q < 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Push with pop only occurs at occupancy 1, where the new word becomes the head.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push, pop})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    head_d = in_data;
                end else begin
                    tail_d = in_data;
                end
            end
            2'b01: begin
                occ_d = occ_q - 2'd1;
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                end
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = in_data;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: rtl/par_gen_stream.sv
// Streaming parity generator (CHECK=0) or checker (CHECK=1) with a 2-entry output buffer
// and a saturating error counter.
module par_gen_stream
    import par_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CHECK  = 0,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    odd_i,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W+CHECK-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W:0]         out_data,
    output logic                    out_err,
    input  logic                    clr_cnt,
    output logic [CNT_W-1:0]        err_cnt
);

    logic             flip;
    logic [DATA_W:0]  word;
    logic             err;
    logic             accept;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        flip = 1'b0;
        case (odd_i)
            PAR_EVEN: flip = 1'b0;
            PAR_ODD:  flip = 1'b1;
            default:  flip = 1'b0;
        endcase
    end

    if (CHECK != 0) begin : g_checker
        // A received word is good when its full XOR equals the requested sense.
        always_comb begin
            word = in_data[DATA_W:0];
            err  = parity(PAR_MAX_W'(in_data[DATA_W:0])) ^ flip;
        end
    end else begin : g_generator
        always_comb begin
            word = {parity(PAR_MAX_W'(in_data[DATA_W-1:0])) ^ flip, in_data[DATA_W-1:0]};
            err  = 1'b0;
        end
    end

    par_skid_fifo #(
        .W(DATA_W + 2)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({err, word}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data ({out_err, out_data})
    );

    assign accept = in_valid && in_ready;

    // Clear wins over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && err && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (clr_cnt) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;

endmodule

// File: tb/tb_par_gen_stream.sv
// Directed and random checks of a generator instance and a 2-bit-counter checker instance
// against a queue-based reference model.
module tb_par_gen_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       g_odd = 1'b0, g_in_valid = 1'b0, g_out_ready = 1'b1, g_clr = 1'b0;
    logic [6:0] g_in_data = '0;
    logic       g_in_ready, g_out_valid, g_out_err;
    logic [7:0] g_out_data;
    logic [7:0] g_err_cnt;

    logic       c_odd = 1'b0, c_in_valid = 1'b0, c_out_ready = 1'b1, c_clr = 1'b0;
    logic [7:0] c_in_data = '0;
    logic       c_in_ready, c_out_valid, c_out_err;
    logic [7:0] c_out_data;
    logic [1:0] c_err_cnt;

    always #5 clk = ~clk;

    par_gen_stream #(.DATA_W(7), .CHECK(0), .CNT_W(8)) u_gen (
        .clk(clk), .rst_n(rst_n), .odd_i(g_odd), .in_valid(g_in_valid), .in_ready(g_in_ready),
        .in_data(g_in_data), .out_valid(g_out_valid), .out_ready(g_out_ready),
        .out_data(g_out_data), .out_err(g_out_err), .clr_cnt(g_clr), .err_cnt(g_err_cnt)
    );

    par_gen_stream #(.DATA_W(7), .CHECK(1), .CNT_W(2)) u_chk (
        .clk(clk), .rst_n(rst_n), .odd_i(c_odd), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_err(c_out_err), .clr_cnt(c_clr), .err_cnt(c_err_cnt)
    );

    int         total = 0;
    int         bad = 0;
    logic [8:0] gq[$];
    logic [8:0] cq[$];
    logic [7:0] g_seen[$];
    int         c_cnt_m = 0;
    bit         g_acc = 1'b0;
    bit         c_acc = 1'b0;
    int         exp_sat[5] = '{1, 2, 3, 3, 3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("g_out_valid", 32'(g_out_valid), 32'(gq.size() > 0));
        chk("g_in_ready", 32'(g_in_ready), 32'(gq.size() < 2));
        chk("g_err_cnt", 32'(g_err_cnt), 32'd0);
        if (gq.size() > 0) begin
            chk("g_out_data", 32'(g_out_data), 32'(gq[0][7:0]));
            chk("g_out_err", 32'(g_out_err), 32'(gq[0][8]));
        end
        chk("c_out_valid", 32'(c_out_valid), 32'(cq.size() > 0));
        chk("c_in_ready", 32'(c_in_ready), 32'(cq.size() < 2));
        chk("c_err_cnt", 32'(c_err_cnt), 32'(c_cnt_m));
        if (cq.size() > 0) begin
            chk("c_out_data", 32'(c_out_data), 32'(cq[0][7:0]));
            chk("c_out_err", 32'(c_out_err), 32'(cq[0][8]));
        end
    endtask

    // One clock: predict from pre-edge model state, update at the edge, check 1 time unit later.
    task automatic cycle();
        logic [8:0] ge, ce, t;
        logic       gp, cerr;
        bit         ga, gd, ca, cd;
        ga   = g_in_valid && (gq.size() < 2);
        gd   = g_out_ready && (gq.size() > 0);
        ca   = c_in_valid && (cq.size() < 2);
        cd   = c_out_ready && (cq.size() > 0);
        gp   = 1'((($countones(g_in_data) + int'(g_odd)) % 2) == 1);
        ge   = {1'b0, gp, g_in_data};
        cerr = 1'(($countones(c_in_data) % 2) != int'(c_odd));
        ce   = {cerr, c_in_data};
        @(posedge clk);
        if (gd) begin
            t = gq.pop_front();
            g_seen.push_back(t[7:0]);
        end
        if (ga) gq.push_back(ge);
        if (cd) void'(cq.pop_front());
        if (ca) cq.push_back(ce);
        if (c_clr) c_cnt_m = 0;
        else if (ca && cerr && c_cnt_m < 3) c_cnt_m++;
        g_acc = ga;
        c_acc = ca;
        #1;
        check_all();
    endtask

    initial begin
        #12;
        chk("rst_g_out_valid", 32'(g_out_valid), 32'd0);
        chk("rst_g_in_ready", 32'(g_in_ready), 32'd1);
        chk("rst_g_out_data", 32'(g_out_data), 32'd0);
        chk("rst_c_out_err", 32'(c_out_err), 32'd0);
        chk("rst_c_err_cnt", 32'(c_err_cnt), 32'd0);
        #1;
        rst_n = 1'b1;

        // Generator directed: even then odd parity on the same payload.
        g_in_valid = 1'b1; g_in_data = 7'b0000011; g_odd = 1'b0;
        cycle();
        chk("gen_even", 32'(g_out_data), 32'h03);
        chk("gen_even_valid", 32'(g_out_valid), 32'd1);
        g_odd = 1'b1;
        cycle();
        chk("gen_odd", 32'(g_out_data), 32'h83);
        g_in_valid = 1'b0; g_odd = 1'b0;
        cycle();

        // Full-rate sweep of all payloads.
        g_seen.delete();
        for (int i = 0; i < 128; i++) begin
            g_in_valid = 1'b1; g_in_data = 7'(i);
            cycle();
            chk("sweep_accept", 32'(g_acc), 32'd1);
        end
        g_in_valid = 1'b0;
        cycle();
        chk("sweep_count", 32'(g_seen.size()), 32'd128);

        // Backpressure: two words fill the buffer, the third waits.
        g_seen.delete();
        g_out_ready = 1'b0; g_in_valid = 1'b1; g_in_data = 7'h11;
        cycle();
        g_in_data = 7'h22;
        cycle();
        g_in_data = 7'h33;
        chk("bp_full_ready", 32'(g_in_ready), 32'd0);
        cycle();
        cycle();
        chk("bp_stall_head", 32'(g_out_data), 32'h11);
        g_out_ready = 1'b1;
        cycle();
        cycle();
        g_in_valid = 1'b0;
        cycle();
        chk("bp_count", 32'(g_seen.size()), 32'd3);
        if (g_seen.size() == 3) begin
            chk("bp_order0", 32'(g_seen[0]), 32'h11);
            chk("bp_order1", 32'(g_seen[1]), 32'h22);
            chk("bp_order2", 32'(g_seen[2]), 32'h33);
        end

        // Checker directed.
        c_in_valid = 1'b1; c_in_data = 8'b00000011; c_odd = 1'b0;
        cycle();
        chk("chk_good_even", 32'(c_out_err), 32'd0);
        c_in_data = 8'b10000011;
        cycle();
        chk("chk_bad_even", 32'(c_out_err), 32'd1);
        chk("chk_cnt1", 32'(c_err_cnt), 32'd1);
        c_odd = 1'b1;
        cycle();
        chk("chk_good_odd", 32'(c_out_err), 32'd0);
        c_in_valid = 1'b0; c_odd = 1'b0;
        cycle();

        // Saturation and clear priority.
        c_clr = 1'b1;
        cycle();
        c_clr = 1'b0;
        c_in_valid = 1'b1; c_in_data = 8'h83;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("sat_cnt", 32'(c_err_cnt), 32'(exp_sat[i]));
        end
        c_clr = 1'b1;
        cycle();
        chk("sat_clear", 32'(c_err_cnt), 32'd0);
        c_clr = 1'b0; c_in_valid = 1'b0;
        cycle();

        // Random traffic on both instances; producers hold a word until it is taken.
        g_acc = 1'b1; c_acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!g_in_valid || g_acc) begin
                g_in_valid = ($urandom_range(0, 3) != 0);
                g_in_data  = 7'($urandom);
                g_odd      = 1'($urandom);
            end
            if (!c_in_valid || c_acc) begin
                c_in_valid = ($urandom_range(0, 3) != 0);
                c_in_data  = 8'($urandom);
                c_odd      = 1'($urandom);
            end
            g_out_ready = ($urandom_range(0, 3) != 0);
            c_out_ready = ($urandom_range(0, 3) != 0);
            g_clr       = ($urandom_range(0, 15) == 0);
            c_clr       = ($urandom_range(0, 15) == 0);
            cycle();
        end

        // Reset with both buffers full.
        g_in_valid = 1'b0; c_in_valid = 1'b0; g_clr = 1'b0; c_clr = 1'b0;
        g_out_ready = 1'b1; c_out_ready = 1'b1;
        cycle();
        cycle();
        g_out_ready = 1'b0; c_out_ready = 1'b0;
        g_in_valid = 1'b1; g_in_data = 7'h21; g_odd = 1'b0;
        c_in_valid = 1'b1; c_in_data = 8'h83; c_odd = 1'b0;
        cycle();
        cycle();
        chk("pre_rst_full", 32'(g_in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_g_valid", 32'(g_out_valid), 32'd0);
        chk("mid_rst_g_ready", 32'(g_in_ready), 32'd1);
        chk("mid_rst_g_data", 32'(g_out_data), 32'd0);
        chk("mid_rst_c_valid", 32'(c_out_valid), 32'd0);
        chk("mid_rst_c_ready", 32'(c_in_ready), 32'd1);
        chk("mid_rst_c_cnt", 32'(c_err_cnt), 32'd0);
        chk("mid_rst_c_err", 32'(c_out_err), 32'd0);
        gq.delete(); cq.delete(); c_cnt_m = 0;
        #2;
        rst_n = 1'b1;
        g_out_ready = 1'b1; c_out_ready = 1'b1;
        g_in_data = 7'h55; c_in_valid = 1'b0;
        cycle();
        chk("post_rst_word", 32'(g_out_data), 32'h55);
        g_in_valid = 1'b0;
        cycle();
        chk("post_rst_alone", 32'(g_out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
